// File: rtl/count_sequencer_ctrl.sv
// Sequencer for a small up/down counter: start/pause/resume/stop, preload,
// programmable terminal count, one-shot or auto-reload, with a run counter.
module count_sequencer_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CYC_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse,
  output logic [CYC_W-1:0] cycles
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] lim_r;
  logic             dir_r;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] start_live;
  logic [WIDTH-1:0] start_reg;
  logic             at_target;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                             input logic [WIDTH-1:0] m);
    return (v > m) ? m : v;
  endfunction

  assign target     = dir_r ? lim_r : '0;
  assign start_live = dir ? '0 : limit;
  assign start_reg  = dir_r ? '0 : lim_r;
  assign at_target  = (q == target);

  // State register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; stop outranks start, which outranks load
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!stop && start) state_nxt = RUN;
      RUN: begin
        if (stop)                           state_nxt = PAUSE;
        else if (at_target && !auto_reload) state_nxt = DONE;
      end
      PAUSE: begin
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = RUN;
      end
      DONE: begin
        if (stop)       state_nxt = IDLE;
        else if (start) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status decoded from registered state and q only
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    tc_pulse = 1'b0;
    busy     = (state == RUN);
    done     = (state == DONE);
    tc_pulse = (state == RUN) && at_target;
  end

  // Counter datapath, latched limit/direction and completed-run counter
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q      <= '0;
      lim_r  <= '0;
      dir_r  <= 1'b1;
      cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!stop) begin
            if (start) begin
              lim_r  <= limit;
              dir_r  <= dir;
              cycles <= '0;
              q      <= start_live;
            end else if (load) begin
              q <= clamp(load_val, limit);
            end
          end
        end
        RUN: begin
          if (!stop) begin
            if (at_target) begin
              if (!(&cycles)) cycles <= cycles + CYC_W'(1);
              if (auto_reload) q <= start_reg;
            end else if (dir_r && (q > lim_r)) begin
              // resumed beyond the target: land on it so tc still fires
              q <= lim_r;
            end else if (dir_r) begin
              q <= q + WIDTH'(1);
            end else begin
              q <= q - WIDTH'(1);
            end
          end
        end
        PAUSE: begin
          if (stop)                q <= '0;
          else if (!start && load) q <= clamp(load_val, lim_r);
        end
        DONE: begin
          if (stop) begin
            q <= '0;
          end else if (start) begin
            lim_r <= limit;
            dir_r <= dir;
            q     <= start_live;
          end
        end
        default: q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_count_sequencer_ctrl.sv
// Directed bench for count_sequencer_ctrl: vector table plus hand-written
// sequences for async reset, auto-reload passes and cycle-count saturation.
module tb_count_sequencer_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  logic       start, stop, load, dir, auto_reload;
  logic [3:0] load_val, limit;
  logic [3:0] q;
  logic       busy, done, tc_pulse;
  logic [7:0] cycles;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       st, sp, ld;
    logic [3:0] lv, lim;
    logic       d, ar;
    logic [3:0] eq;
    logic       eb, ed, et;
    logic [7:0] ec;
  } vec_t;

  vec_t vecs[$];

  count_sequencer_ctrl #(.WIDTH(4), .CYC_W(8)) dut (
    .clk(clk), .clear(clear), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .limit(limit), .dir(dir), .auto_reload(auto_reload),
    .q(q), .busy(busy), .done(done), .tc_pulse(tc_pulse), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq, input logic eb,
                         input logic ed, input logic et, input logic [7:0] ec);
    chk({tag, "_q"},      32'(q),        32'(eq));
    chk({tag, "_busy"},   32'(busy),     32'(eb));
    chk({tag, "_done"},   32'(done),     32'(ed));
    chk({tag, "_tc"},     32'(tc_pulse), 32'(et));
    chk({tag, "_cycles"}, 32'(cycles),   32'(ec));
  endtask

  task automatic drive(input logic st, input logic sp, input logic ld, input logic [3:0] lv,
                       input logic [3:0] lim, input logic d, input logic ar);
    start = st; stop = sp; load = ld; load_val = lv; limit = lim; dir = d; auto_reload = ar;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic st, input logic sp, input logic ld,
                              input logic [3:0] lv, input logic [3:0] lim,
                              input logic d, input logic ar, input logic [3:0] eq,
                              input logic eb, input logic ed, input logic et,
                              input logic [7:0] ec);
    vec_t v;
    v.st = st; v.sp = sp; v.ld = ld; v.lv = lv; v.lim = lim; v.d = d; v.ar = ar;
    v.eq = eq; v.eb = eb; v.ed = ed; v.et = et; v.ec = ec;
    vecs.push_back(v);
  endfunction

  initial begin
    // One-shot up, limit 9
    add(1,0,0, 0, 9,1,0,  0, 1,0,0, 0);
    for (int k = 1; k <= 8; k++) add(0,0,0, 0, 9,1,0, 4'(k), 1,0,0, 0);
    add(0,0,0, 0, 9,1,0,  9, 1,0,1, 0);
    add(0,0,0, 0, 9,1,0,  9, 0,1,0, 1);
    add(0,0,1, 3, 9,1,0,  9, 0,1,0, 1);   // load ignored in DONE
    add(0,1,0, 0, 9,1,0,  0, 0,0,0, 1);   // stop: DONE -> IDLE
    add(0,0,1,15, 6,1,0,  6, 0,0,0, 1);   // IDLE load clamps to live limit
    add(0,0,1, 3, 6,1,0,  3, 0,0,0, 1);
    add(1,0,1, 2, 6,1,0,  0, 1,0,0, 0);   // start beats load
    add(0,0,0, 0, 6,1,0,  1, 1,0,0, 0);
    add(1,1,0, 0, 6,1,0,  1, 0,0,0, 0);   // stop beats start in RUN
    add(0,0,0, 0, 6,1,0,  1, 0,0,0, 0);
    add(1,1,0, 0, 6,1,0,  0, 0,0,0, 0);   // stop beats start in PAUSE
    // Down run with live limit/dir changes that must not take effect
    add(1,0,0, 0, 3,0,0,  3, 1,0,0, 0);
    add(0,0,0, 0, 9,1,0,  2, 1,0,0, 0);
    add(0,0,0, 0, 9,1,0,  1, 1,0,0, 0);
    add(0,0,0, 0, 9,1,0,  0, 1,0,1, 0);
    add(0,0,0, 0, 9,1,0,  0, 0,1,0, 1);
    add(0,1,0, 0, 9,1,0,  0, 0,0,0, 1);
    // Pause/resume with clamped preload
    add(1,0,0, 0,12,1,0,  0, 1,0,0, 0);
    for (int k = 1; k <= 4; k++) add(0,0,0, 0,12,1,0, 4'(k), 1,0,0, 0);
    add(0,1,0, 0,12,1,0,  4, 0,0,0, 0);
    for (int k = 0; k < 3; k++) add(0,0,0, 0,12,1,0, 4, 0,0,0, 0);
    add(0,0,1,15,15,1,0, 12, 0,0,0, 0);   // clamp uses latched limit 12
    add(1,0,0, 0,15,1,0, 12, 1,0,1, 0);
    add(0,0,0, 0,15,1,0, 12, 0,1,0, 1);
    add(0,1,0, 0,15,1,0,  0, 0,0,0, 1);

    // Reset state
    clear = 1'b0;
    drive(0,0,0, 0, 9,1,0);
    step(); step();
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk) clear = 1'b1;

    // Reset mid-count, asserted between edges
    drive(1,0,0, 0, 9,1,0);
    step();
    drive(0,0,0, 0, 9,1,0);
    repeat (5) step();
    chk("midcount_q_before", 32'(q), 32'd5);
    #2 clear = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk) clear = 1'b1;

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].ld, vecs[i].lv, vecs[i].lim, vecs[i].d, vecs[i].ar);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eb, vecs[i].ed, vecs[i].et, vecs[i].ec);
    end

    // Auto-reload down, limit 5
    drive(1,0,0, 0, 5,0,1);
    step();
    chk_all("ar_start", 5, 1, 0, 0, 0);
    drive(0,0,0, 0, 5,0,1);
    for (int p = 0; p < 2; p++) begin
      for (int v = 4; v >= 0; v--) begin
        step();
        chk_all($sformatf("ar_p%0d_v%0d", p, v), 4'(v), 1, 0, (v == 0), 8'(p));
      end
      step();
      chk_all($sformatf("ar_p%0d_reload", p), 5, 1, 0, 0, 8'(p + 1));
    end
    step(); step();
    chk("ar_p2_q3", 32'(q), 32'd3);
    drive(0,0,0, 0, 5,0,0);
    step(); step();
    step();
    chk_all("ar_p2_last", 0, 1, 0, 1, 2);
    step();
    chk_all("ar_done", 0, 0, 1, 0, 3);
    drive(0,1,0, 0, 5,0,0);
    step();
    chk_all("ar_stop", 0, 0, 0, 0, 3);

    // Saturation: limit 0, up, auto-reload
    drive(1,0,0, 0, 0,1,1);
    step();
    chk_all("sat_start", 0, 1, 0, 1, 0);
    drive(0,0,0, 0, 0,1,1);
    for (int n = 1; n <= 300; n++) begin
      step();
      if (n == 1)   chk_all("sat_n1", 0, 1, 0, 1, 1);
      if (n == 254) chk("sat_n254", 32'(cycles), 32'd254);
      if (n == 255) chk_all("sat_n255", 0, 1, 0, 1, 255);
      if (n == 300) chk_all("sat_n300", 0, 1, 0, 1, 255);
    end

    // Async reset clears a saturated counter immediately
    #2 clear = 1'b0;
    #1;
    chk_all("async_reset_sat", 0, 0, 0, 0, 0);
    @(negedge clk) clear = 1'b1;
    step();
    chk_all("post_reset_idle", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_sequencer_ctrl.md
Name: count_sequencer_ctrl

Overview:
- Controller that sequences a 4-bit synchronous counter datapath: start/pause/resume/stop, preload, up/down direction, programmable terminal count, one-shot or auto-reload.
- Sits between the lab control panel (switches/buttons) and the counter display path.
- Provides status (busy, done, terminal-count pulse) and a completed-cycle count for downstream sequencing logic.

Parameters:
- WIDTH, 4, counter width in bits.
- CYC_W, 8, width of completed-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  asynchronous active-low reset.
- start  input  1  start (from IDLE/DONE) or resume (from PAUSE).
- stop  input  1  pause (from RUN), abort to IDLE (from PAUSE/DONE).
- load  input  1  preload q from load_val (IDLE/PAUSE only).
- load_val  input  WIDTH  preload value.
- limit  input  WIDTH  terminal count; latched on start from IDLE/DONE.
- dir  input  1  1=up, 0=down; latched with limit.
- auto_reload  input  1  1=reload and continue at terminal count; sampled live.
- q  output  WIDTH  counter value.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- tc_pulse  output  1  high while in RUN with q at target.
- cycles  output  CYC_W  completed runs; saturates at all-ones.

Behaviour:
- Reset (clear=0, async): state=IDLE, q=0, lim_r=0, dir_r=1, cycles=0; busy=done=tc_pulse=0. Deassertion is synchronous to clk.
- States: IDLE, RUN, PAUSE, DONE. All transitions on rising clk.
- Command priority when several are asserted in the same cycle: stop > start > load.
- IDLE:
  - start: lim_r<=limit, dir_r<=dir, cycles<=0, q<=start value (0 if up, limit if down) -> RUN.
  - load: q<=min(load_val, limit); stay IDLE.
- RUN: target = lim_r if dir_r=1, else 0.
  - stop: -> PAUSE, q holds.
  - q==target: tc_pulse=1 this cycle. At the next edge, cycles<=cycles+1 (saturating). Then:
    - auto_reload=1: q<=start value (from lim_r/dir_r), stay RUN.
    - auto_reload=0: -> DONE, q holds target.
  - Otherwise: q<=q+1 (up) or q-1 (down). No wrap beyond target.
  - start and load are ignored in RUN.
- PAUSE:
  - start: -> RUN, counting resumes from held q. lim_r/dir_r are unchanged.
  - stop: -> IDLE, q<=0.
  - load: q<=min(load_val, lim_r).
  - If the resumed q is past the target (up: q>lim_r), the next RUN edge forces q<=target; no tc is skipped.
- DONE: done=1, q holds.
  - start: relatch limit/dir, q<=start value, -> RUN; cycles is not cleared.
  - stop: -> IDLE, q<=0.
  - load: ignored.
- Outputs are decoded from registered state and q; no combinational path from inputs.
  - busy = (state==RUN).
  - done = (state==DONE).
  - tc_pulse = busy & (q==target).
- limit=0, up, auto_reload=1: q stays 0 and tc_pulse is high every RUN cycle.
- Live changes to limit or dir during RUN/PAUSE have no effect until the next start from IDLE/DONE.

Test Plan:
- Reset mid-count: limit=9, up, run to q=5, drop clear asynchronously between edges -> q=0, busy=0, cycles=0 immediately, without waiting for a clock edge.
- One-shot up, limit=9, start pulsed at edge 0 -> q=0 after edge 0 … q=9 after edge 9. tc_pulse high only during q=9. Edge 10: done=1, busy=0, q=9, cycles=1.
- Auto-reload down, limit=5, auto_reload=1 -> q sequence 5,4,3,2,1,0,5,4… tc_pulse high at each q=0. cycles=2 after the second 0 completes. Clearing auto_reload during the third pass -> DONE at q=0 with cycles=3.
- Pause/resume with preload: up, limit=12, stop at q=4 -> PAUSE, q=4 held for 3 cycles. load_val=15 -> q=12 (clamped). start -> tc_pulse next cycle, then DONE.
- Priority: start and stop asserted together in RUN -> PAUSE. Both asserted in PAUSE -> IDLE with q=0. start and load together in IDLE -> RUN from start value (load ignored).
- Saturation: CYC_W=8, limit=0, auto_reload=1, run 300 cycles -> cycles=255 and stays 255.
